// File: rtl/pulse_stretch.sv
// pulse_stretch: turns one-cycle trigger events into a high level of
// programmable length, followed by a forced low gap so a downstream edge
// detector sees every output as a separate rising edge. Triggers that are
// not honoured are tallied in a saturating counter.
module pulse_stretch #(
  parameter int LEN_BITS   = 16,
  parameter int GAP_CYCLES = 2,
  parameter int DROP_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 trigger,
  input  logic [LEN_BITS-1:0]  length,
  input  logic                 retrigger_en,
  output logic                 level,
  output logic                 busy,
  output logic                 done,
  output logic [DROP_BITS-1:0] dropped
);

  // Gap counter needs at least one bit even when the gap is disabled.
  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  state_t              state;
  logic [LEN_BITS-1:0] counter;
  logic [GAP_W-1:0]    gap_cnt;
  logic                len_ok;
  logic                reload;
  logic                drop_evt;

  // Classify the current trigger: accepted reload, or dropped event.
  always_comb begin
    len_ok   = (length != '0);
    reload   = (state == ACTIVE) && trigger && retrigger_en && len_ok;
    drop_evt = trigger && ((state == GAP) || ((state == ACTIVE) && !reload));
  end

  assign busy = (state != IDLE);

  // Main sequencer: counter holds the remaining high cycles including the
  // current one, so the output ends in the cycle where it reads 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      gap_cnt <= '0;
      level   <= 1'b0;
      done    <= 1'b0;
      dropped <= '0;
    end else begin
      done <= 1'b0;
      if (drop_evt && (dropped != '1)) begin
        dropped <= dropped + DROP_BITS'(1);
      end
      unique case (state)
        IDLE: begin
          if (trigger && len_ok) begin
            state   <= ACTIVE;
            counter <= length;
            level   <= 1'b1;
          end
        end
        ACTIVE: begin
          if (reload) begin
            counter <= length;
          end else if (counter == LEN_BITS'(1)) begin
            counter <= '0;
            level   <= 1'b0;
            done    <= 1'b1;
            if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_W'(GAP_CYCLES);
            end else begin
              state <= IDLE;
            end
          end else begin
            counter <= counter - LEN_BITS'(1);
          end
        end
        GAP: begin
          if (gap_cnt <= GAP_W'(1)) begin
            state   <= IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pulse_stretch.md
Name: pulse_stretch

Overview:
Converts single-cycle trigger pulses into a clean high level of programmable length. It is the inverse of the team's level-to-pulse edge detector. Typical uses are driving LEDs, enables or external strobes from one-cycle events. A guaranteed minimum low gap after each output lets a downstream edge detector see every output as a distinct rising edge. A saturating counter records triggers that were not honoured.

Parameters:
LEN_BITS, 16, width of the length input and of the internal down-counter.
GAP_CYCLES, 2, forced low cycles after each output level ends (0 allowed).
DROP_BITS, 8, width of the saturating dropped-trigger counter.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
trigger  input  1  event input; every cycle it is high counts as one trigger event
length  input  LEN_BITS  output high time in cycles, sampled only in the cycle a trigger is accepted
retrigger_en  input  1  1: a trigger while active reloads the length; 0: it is dropped
level  output  1  stretched output, registered
busy  output  1  high in ACTIVE and GAP states (combinational from state)
done  output  1  one-cycle pulse, registered, in the first low cycle after an output ends
dropped  output  DROP_BITS  saturating count of triggers rejected while busy

Behaviour:
- Reset, synchronous and active-high, sampled at the clk edge:
  - state=IDLE, counter=0, level=0, done=0, dropped=0.
  - A reset in any state aborts immediately; level=0 in the cycle after reset is sampled.
  - No done is generated on reset.
- States: IDLE, ACTIVE, GAP. level=1 only in ACTIVE.
- IDLE:
  - trigger=1 with length!=0 at cycle T: go to ACTIVE and load counter=length. level is high for exactly cycles T+1..T+length.
  - trigger=1 with length=0: ignored; no state change, not counted as dropped.
- ACTIVE:
  - counter decrements once per cycle.
  - In the cycle where counter==1 and no reload happens: go to GAP if GAP_CYCLES>0, otherwise IDLE. done=1 in the next cycle, i.e. cycle T+length+1.
  - trigger=1 at cycle U with retrigger_en=1 and length!=0: reload counter=length. level stays high through cycle U+length.
  - A reload on the final active cycle (counter==1) extends the output with no low cycle and no done.
  - trigger=1 with retrigger_en=0, or with length=0: dropped; dropped increments.
- GAP:
  - Lasts exactly GAP_CYCLES cycles: T+length+1 .. T+length+GAP_CYCLES. Then IDLE.
  - level=0 throughout.
  - Every trigger cycle in GAP is dropped and counted, regardless of retrigger_en.
- Earliest accepted new trigger is cycle T+length+GAP_CYCLES+1. Consequence: consecutive outputs are separated by at least GAP_CYCLES+1 low cycles.
- dropped saturates at 2^DROP_BITS-1 and never wraps. It is cleared only by reset.
- trigger held high continuously:
  - retrigger_en=1: level stays high for as long as trigger is high, plus length cycles.
  - retrigger_en=0: pulses repeat with period length+GAP_CYCLES+1. Every cycle in ACTIVE/GAP increments dropped.
- Counter arithmetic is unsigned LEN_BITS. Maximum high time is 2^LEN_BITS-1 cycles.

Test Plan:
- Basic pulse, GAP_CYCLES=2: trigger at cycle 10, length=5 -> level=1 cycles 11-15; done=1 at cycle 16 only; busy cycles 11-17; IDLE at 18.
- Retrigger with retrigger_en=1: trigger at 10 (length=5), trigger at 13 (length=4) -> level=1 cycles 11-17 continuously, single done at 18, dropped=0.
- No retrigger: same stimulus with retrigger_en=0 -> level=1 cycles 11-15; dropped=1. Then triggers at 16 and 17 (GAP) -> dropped=3. Trigger at 18 -> level=1 cycles 19-23.
- Final-cycle reload: trigger at 10 (length=3), retrigger at 13 (length=2) -> level=1 cycles 11-15 with no low cycle in between; done only at 16.
- Boundaries:
  - length=0 in IDLE -> no output, dropped unchanged.
  - DROP_BITS=2: 6 dropped triggers -> dropped stops at 3.
  - length=1 -> exactly one high cycle.
  - GAP_CYCLES=0 -> trigger accepted at T+length+1, leaving exactly one low cycle.
- Reset mid-operation: reset high at cycle 13 during a length=8 pulse started at 10 -> level=0, done=0, dropped=0 from cycle 14. A trigger at 14 is accepted normally.
